// File: rtl/psum_pkg.sv
// Shared constants, lane types and the saturating / activation arithmetic used
// by the partial-sum accumulator and its write-back FIFO.
package psum_pkg;

    localparam int LANES       = 4;
    localparam int PSUM_W      = 16;
    localparam int BIAS_W      = 8;
    localparam int ACT_W       = 8;
    localparam int DEPTH       = 64;
    localparam int ADDR_W      = 6;
    localparam int SHIFT       = 4;
    localparam int OFIFO_DEPTH = 16;
    localparam int PTR_W       = $clog2(OFIFO_DEPTH);
    localparam int FCNT_W      = PTR_W + 1;
    localparam int OADDR_W     = 10;
    localparam logic [OADDR_W-1:0] OUT_BASE = 10'd512;

    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic [ACT_W-1:0] act_t;

    // Add with one guard bit; a disagreeing guard/sign pair means the true sum left the range.
    function automatic psum_t sat_add(input psum_t a, input psum_t b);
        logic signed [PSUM_W:0] s;
        s = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
        if (s[PSUM_W] != s[PSUM_W-1])
            return s[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
        return s[PSUM_W-1:0];
    endfunction

    function automatic act_t relu_shift_clip(input psum_t s);
        psum_t sh;
        if (s[PSUM_W-1])
            return '0;
        sh = s >>> SHIFT;
        if (|sh[PSUM_W-1:ACT_W])
            return '1;
        return sh[ACT_W-1:0];
    endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Write-back FIFO: accepts a whole lane group per push, drains one byte per pop,
// and reports its free entry count so the producer can check room up front.
module psum_out_fifo
    import psum_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [LANES*ACT_W-1:0] pushData,
    input  logic                   pop,
    output act_t                   headData,
    output logic                   valid,
    output logic [FCNT_W-1:0]      free
);

    act_t              entries [OFIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [FCNT_W-1:0] count;

    // The producer guarantees room before pushing; the consumer only pops when valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < OFIFO_DEPTH; i++)
                entries[i] <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < LANES; i++)
                    entries[wrPtr + PTR_W'(i)] <= pushData[i*ACT_W +: ACT_W];
                wrPtr <= wrPtr + PTR_W'(LANES);
            end
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            count <= count + (push ? FCNT_W'(LANES) : '0) - (pop ? FCNT_W'(1) : '0);
        end
    end

    assign valid    = (count != '0);
    assign headData = entries[rdPtr];
    assign free     = FCNT_W'(OFIFO_DEPTH) - count;

endmodule

// File: rtl/psum_accum_wb.sv
// Partial-sum accumulator row with bias fold-in, saturating accumulation and a
// ReLU/shift/clip write-back path into the DRAM output FIFO.
module psum_accum_wb
    import psum_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psumEn,
    input  logic                    first,
    input  logic                    last,
    input  logic [ADDR_W-1:0]       headAddress,
    input  logic                    pusmclear,
    input  logic [LANES*PSUM_W-1:0] psum_in,
    input  logic [BIAS_W-1:0]       bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACT_W-1:0]        out_data,
    output logic [OADDR_W-1:0]      out_addr,
    output logic                    overflow
);

    localparam int RW = FCNT_W + 1;

    psum_t                   acc      [DEPTH];
    logic [ADDR_W-1:0]       laneAddr [LANES];
    psum_t                   laneBase [LANES];
    psum_t                   newSum   [LANES];
    logic [LANES*ACT_W-1:0]  groupData;
    logic [FCNT_W-1:0]       fifoFree;
    logic [RW-1:0]           roomCount;
    logic                    fifoPop;
    logic                    groupIssue;
    logic                    pushGroup;

    // A clear in the same cycle reads as a zero stored base, so lanes never see stale data.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            laneAddr[i] = headAddress + ADDR_W'(i);
            if (first)
                laneBase[i] = {{(PSUM_W-BIAS_W){bias[BIAS_W-1]}}, bias};
            else if (pusmclear)
                laneBase[i] = '0;
            else
                laneBase[i] = acc[laneAddr[i]];
            newSum[i] = sat_add(laneBase[i], psum_in[i*PSUM_W +: PSUM_W]);
            groupData[i*ACT_W +: ACT_W] = relu_shift_clip(newSum[i]);
        end
    end

    assign fifoPop    = out_valid && out_ready;
    assign roomCount  = {1'b0, fifoFree} + RW'(fifoPop);
    assign groupIssue = psumEn && last;
    assign pushGroup  = groupIssue && (roomCount >= RW'(LANES));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                acc[j] <= '0;
        end else begin
            if (pusmclear)
                for (int j = 0; j < DEPTH; j++)
                    acc[j] <= '0;
            if (psumEn)
                for (int i = 0; i < LANES; i++)
                    acc[laneAddr[i]] <= newSum[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr <= OUT_BASE;
            overflow <= 1'b0;
        end else begin
            if (fifoPop)
                out_addr <= out_addr + OADDR_W'(1);
            if (groupIssue && !pushGroup)
                overflow <= 1'b1;
        end
    end

    psum_out_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushGroup),
        .pushData (groupData),
        .pop      (fifoPop),
        .headData (out_data),
        .valid    (out_valid),
        .free     (fifoFree)
    );

endmodule

// File: tb/tb_psum_accum_wb.sv
// Self-checking bench for psum_accum_wb: directed scenarios plus randomized traffic,
// all compared against an arithmetic model holding the row as ints and the FIFO as a queue.
module tb_psum_accum_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        psumEn;
    logic        first;
    logic        last;
    logic [5:0]  headAddress;
    logic        pusmclear;
    logic [63:0] psum_in;
    logic [7:0]  bias;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [9:0]  out_addr;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    int refMem [64];
    int refQ [$];
    int refAddr;
    bit refOvf;
    int lanes [4];

    psum_accum_wb dut (
        .clk         (clk),
        .rst         (rst),
        .psumEn      (psumEn),
        .first       (first),
        .last        (last),
        .headAddress (headAddress),
        .pusmclear   (pusmclear),
        .psum_in     (psum_in),
        .bias        (bias),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic int satw(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int act(input int s);
        int q;
        if (s < 0) return 0;
        q = s / 16;
        return (q > 255) ? 255 : q;
    endfunction

    // One clock: model the edge from the currently driven inputs, then sample 1ns after it.
    task automatic stepCycle();
        int sums [4];
        int pop;
        int h;
        int b;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = lanes[i];
            psum_in[i*16 +: 16] = tmp[15:0];
        end
        h = int'(headAddress);
        b = int'($signed(bias));
        if (rst) begin
            foreach (refMem[k]) refMem[k] = 0;
            refQ.delete();
            refAddr = 512;
            refOvf = 0;
        end else begin
            pop = (refQ.size() > 0 && out_ready) ? 1 : 0;
            for (int i = 0; i < 4; i++)
                sums[i] = satw((first ? b : (pusmclear ? 0 : refMem[(h + i) % 64])) + lanes[i]);
            if (pusmclear)
                foreach (refMem[k]) refMem[k] = 0;
            if (psumEn)
                for (int i = 0; i < 4; i++) refMem[(h + i) % 64] = sums[i];
            if (psumEn && last) begin
                if (16 - refQ.size() + pop >= 4)
                    for (int i = 0; i < 4; i++) refQ.push_back(act(sums[i]));
                else
                    refOvf = 1;
            end
            if (pop == 1) begin
                void'(refQ.pop_front());
                refAddr = (refAddr + 1) % 1024;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit en, input bit f, input bit l, input bit clr,
                                 input int head, input int b,
                                 input int l0, input int l1, input int l2, input int l3);
        psumEn      = en;
        first       = f;
        last        = l;
        pusmclear   = clr;
        headAddress = 6'(head);
        bias        = 8'(b);
        lanes[0] = l0; lanes[1] = l1; lanes[2] = l2; lanes[3] = l3;
        stepCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drainQueue();
        out_ready = 1'b1;
        for (int i = 0; i < 64 && refQ.size() > 0; i++)
            idleCycles(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        idleCycles(10);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL resetValid got %b expected 0", out_valid); end
        checks++; if (out_addr !== 10'd512) begin errors++; $display("[TB] FAIL resetAddr got %0d expected 512", out_addr); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL resetOvf got %b expected 0", overflow); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("[TB] FAIL resetData got %0d expected 0", out_data); end
    endtask

    task automatic test_bias_accum();
        out_ready = 1'b1;
        applyStimulus(1, 1, 0, 0, 0, 16, 100, 100, 100, 100);
        applyStimulus(1, 0, 0, 0, 0, 16, 20, 20, 20, 20);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL accumNoOut got %b expected 0", out_valid); end
        applyStimulus(1, 0, 1, 0, 0, 16, 24, 24, 24, 24);
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL accumValid k=%0d got %b expected 1", k, out_valid); end
            checks++; if (out_data !== 8'd10) begin errors++; $display("[TB] FAIL accumData k=%0d got %0d expected 10", k, out_data); end
            checks++; if (out_addr !== 10'(512 + k)) begin errors++; $display("[TB] FAIL accumAddr k=%0d got %0d expected %0d", k, out_addr, 512 + k); end
            idleCycles(1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL accumEmpty got %b expected 0", out_valid); end
    endtask

    task automatic test_wrap_saturate();
        int expd [8] = '{0, 255, 3, 4, 0, 5, 0, 255};
        out_ready = 1'b0;
        applyStimulus(1, 1, 0, 0, 62, 0, 0, 32000, 0, 0);
        applyStimulus(1, 0, 1, 0, 62, 0, -50, 32000, 48, 64);
        applyStimulus(1, 1, 1, 0, 62, -16, 16, 100, -200, 4096);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_data !== 8'(expd[k])) begin errors++; $display("[TB] FAIL wrapData k=%0d got %0d expected %0d", k, out_data, expd[k]); end
            checks++; if (out_addr !== 10'(516 + k)) begin errors++; $display("[TB] FAIL wrapAddr k=%0d got %0d expected %0d", k, out_addr, 516 + k); end
            idleCycles(1);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] heldData;
        logic [9:0] heldAddr;
        int pops;
        drainQueue();
        out_ready = 1'b0;
        for (int g = 0; g < 5; g++) begin
            if (g == 4) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovfEarly got %b expected 0", overflow); end
            end
            applyStimulus(1, 1, 1, 0, int'($urandom_range(0, 63)), int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 8191)) - 2048, int'($urandom_range(0, 8191)) - 2048,
                          int'($urandom_range(0, 8191)) - 2048, int'($urandom_range(0, 8191)) - 2048);
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovfSet got %b expected 1", overflow); end
        heldData = out_data;
        heldAddr = out_addr;
        for (int i = 0; i < 3; i++) begin
            idleCycles(1);
            checks++; if (out_data !== heldData || out_addr !== heldAddr) begin errors++; $display("[TB] FAIL stallHold got %0d@%0d expected %0d@%0d", out_data, out_addr, heldData, heldAddr); end
        end
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 40 && out_valid === 1'b1; c++) begin
            checks++; if (refQ.size() == 0 || out_data !== 8'(refQ[0]) || out_addr !== 10'(refAddr)) begin
                errors++; $display("[TB] FAIL ovfDrain pop=%0d got %0d@%0d expected %0d@%0d", pops, out_data, out_addr, (refQ.size() > 0) ? refQ[0] : -1, refAddr); end
            pops++;
            idleCycles(1);
        end
        checks++; if (pops != 16) begin errors++; $display("[TB] FAIL ovfPops got %0d expected 16", pops); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovfSticky got %b expected 1", overflow); end
    endtask

    task automatic test_clear();
        int expd [8] = '{1, 1, 1, 1, 2, 2, 2, 2};
        drainQueue();
        out_ready = 1'b0;
        applyStimulus(1, 0, 0, 1, 8, 0, 7, 7, 7, 7);
        applyStimulus(1, 0, 1, 0, 8, 0, 9, 9, 9, 9);
        applyStimulus(1, 0, 1, 0, 0, 0, 32, 32, 32, 32);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_data !== 8'(expd[k]) || out_addr !== 10'(refAddr)) begin errors++; $display("[TB] FAIL clearData k=%0d got %0d@%0d expected %0d@%0d", k, out_data, out_addr, expd[k], refAddr); end
            idleCycles(1);
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL clearKeepsOvf got %b expected 1", overflow); end
    endtask

    task automatic test_room_with_pop();
        int pops;
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++)
            applyStimulus(1, 1, 1, 0, g * 4, 0, 16 * g, 32, 48, 64);
        out_ready = 1'b1;
        idleCycles(3);
        applyStimulus(1, 1, 1, 0, 40, 0, 160, 176, 192, 208);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL roomPopOvf got %b expected 0", overflow); end
        pops = 0;
        for (int c = 0; c < 40 && out_valid === 1'b1; c++) begin
            checks++; if (refQ.size() == 0 || out_data !== 8'(refQ[0])) begin
                errors++; $display("[TB] FAIL roomPopData pop=%0d got %0d expected %0d", pops, out_data, (refQ.size() > 0) ? refQ[0] : -1); end
            pops++;
            idleCycles(1);
        end
        checks++; if (pops != 16) begin errors++; $display("[TB] FAIL roomPopCount got %0d expected 16", pops); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 99) < 3, int'($urandom_range(0, 63)), int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 4095)) - 1024,
                          int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 8191)));
            checks++; if (out_valid !== (refQ.size() > 0) || overflow !== refOvf || out_addr !== 10'(refAddr)) begin
                errors++; $display("[TB] FAIL randCtl c=%0d got v%b o%b a%0d expected v%b o%b a%0d", c, out_valid, overflow, out_addr, refQ.size() > 0, refOvf, refAddr); end
            if (refQ.size() > 0) begin
                checks++; if (out_data !== 8'(refQ[0])) begin errors++; $display("[TB] FAIL randData c=%0d got %0d expected %0d", c, out_data, refQ[0]); end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_midburst();
        drainQueue();
        out_ready = 1'b0;
        applyStimulus(1, 1, 1, 0, 0, 0, 160, 160, 160, 160);
        out_ready = 1'b1;
        idleCycles(1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midQueued got %b expected 1", out_valid); end
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midValid got %b expected 0", out_valid); end
        checks++; if (out_addr !== 10'd512) begin errors++; $display("[TB] FAIL midAddr got %0d expected 512", out_addr); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL midOvf got %b expected 0", overflow); end
        applyStimulus(1, 0, 1, 0, 0, 0, 32, 32, 32, 32);
        checks++; if (out_data !== 8'd2) begin errors++; $display("[TB] FAIL midMemZero got %0d expected 2", out_data); end
    endtask

    initial begin
        rst = 1'b1; psumEn = 1'b0; first = 1'b0; last = 1'b0; pusmclear = 1'b0;
        headAddress = '0; psum_in = '0; bias = '0; out_ready = 1'b0;
        foreach (lanes[i]) lanes[i] = 0;
        foreach (refMem[i]) refMem[i] = 0;
        refAddr = 512;
        refOvf = 0;
        $display("[TB] starting psum_accum_wb bench");
        test_reset();
        test_bias_accum();
        test_wrap_saturate();
        test_overflow();
        test_clear();
        test_room_with_pop();
        test_random();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
